// File: rtl/uart_tx16_if.sv
// Parallel word handshake between the datapath and the 16-bit UART serializer.
interface uart_tx16_if;
  logic [15:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic        busy;

  modport master (output data_in, output valid_in, input ready_out, input busy);
  modport slave  (input data_in, input valid_in, output ready_out, output busy);
endinterface

// File: rtl/uart_tx16.sv
// 16-bit word serializer: sends each accepted word as two 8N1 frames, low byte first.
module uart_tx16 #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  uart_tx16_if.slave  bus,
  output logic        tx
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            r_state, w_state_n;
  logic [BaudW-1:0]  r_baud, w_baud_n;
  logic [2:0]        r_bit, w_bit_n;
  logic              r_idx, w_idx_n;
  logic [7:0]        r_shift, w_shift_n;
  logic [15:0]       r_hold, w_hold_n;
  logic              r_tx, w_tx_n;
  logic              w_baud_end;

  assign w_baud_end    = (r_baud == BaudMax);
  assign bus.ready_out = (r_state == StIdle);
  assign bus.busy      = (r_state != StIdle);
  assign tx            = r_tx;

  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud;
    w_bit_n   = r_bit;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_hold_n  = r_hold;
    unique case (r_state)
      StIdle: begin
        if (bus.valid_in) begin
          w_hold_n  = bus.data_in;
          w_idx_n   = 1'b0;
          w_baud_n  = '0;
          w_bit_n   = '0;
          w_state_n = StStart;
        end
      end
      StStart: begin
        if (w_baud_end) begin
          w_baud_n  = '0;
          // The byte for this frame is picked at the start/data boundary.
          w_shift_n = r_idx ? r_hold[15:8] : r_hold[7:0];
          w_state_n = StData;
        end else begin
          w_baud_n = r_baud + 1'b1;
        end
      end
      StData: begin
        if (w_baud_end) begin
          w_baud_n = '0;
          if (r_bit == 3'd7) begin
            w_bit_n   = '0;
            w_state_n = StStop;
          end else begin
            w_bit_n   = r_bit + 3'd1;
            w_shift_n = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_baud_n = r_baud + 1'b1;
        end
      end
      StStop: begin
        if (w_baud_end) begin
          w_baud_n = '0;
          if (!r_idx) begin
            w_idx_n   = 1'b1;
            w_state_n = StStart;
          end else begin
            w_idx_n   = 1'b0;
            w_state_n = StIdle;
          end
        end else begin
          w_baud_n = r_baud + 1'b1;
        end
      end
      default: w_state_n = StIdle;
    endcase

    unique case (w_state_n)
      StStart: w_tx_n = 1'b0;
      StData:  w_tx_n = w_shift_n[0];
      default: w_tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_baud  <= '0;
      r_bit   <= '0;
      r_idx   <= 1'b0;
      r_shift <= '0;
      r_hold  <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
      r_hold  <= w_hold_n;
      r_tx    <= w_tx_n;
    end
  end

endmodule
